// File: rtl/dmem_master.sv
// dmem_master: pipeline-to-data-memory initiator FSM (IDLE/ACCESS/RESP).
// Optional access timeout enabled by defining DMEM_MASTER_TIMEOUT_EN.
module dmem_master #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_valid,
    input  logic        mem_good,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    output logic [1:0]  mem_maskMode,
    output logic        mem_sext,
    input  logic [31:0] mem_readData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic   bad;
`ifdef DMEM_MASTER_TIMEOUT_EN
    logic [7:0] cnt;
`endif
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dmem_master: TIMEOUT must be within 1..255");
    end
    // Illegal type encoding, illegal size, or misaligned half/word access
    assign bad = (req_load == req_store) || (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_ready = (state == IDLE);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem_valid     <= 1'b0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
            mem_addr      <= '0;
            mem_writeData <= '0;
            mem_maskMode  <= '0;
            mem_sext      <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= '0;
`ifdef DMEM_MASTER_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    mem_addr      <= req_addr;
                    mem_writeData <= req_wdata;
                    mem_maskMode  <= req_size;
                    mem_sext      <= req_sext;
                    if (bad) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'b01;
                    end else begin
                        state        <= ACCESS;
                        mem_valid    <= 1'b1;
                        mem_memRead  <= req_load;
                        mem_memWrite <= req_store;
`ifdef DMEM_MASTER_TIMEOUT_EN
                        cnt          <= '0;
`endif
                    end
                end
                ACCESS: if (mem_good) begin
                    state        <= RESP;
                    mem_valid    <= 1'b0;
                    mem_memRead  <= 1'b0;
                    mem_memWrite <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= mem_memRead ? mem_readData : 32'h0;
                    resp_err     <= 2'b00;
`ifdef DMEM_MASTER_TIMEOUT_EN
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state        <= RESP;
                    mem_valid    <= 1'b0;
                    mem_memRead  <= 1'b0;
                    mem_memWrite <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= '0;
                    resp_err     <= 2'b10;
                end else begin
                    cnt <= cnt + 8'd1;
`endif
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: directed stimulus with a response scoreboard queue checked by a monitor.
module tb_dmem_master;
    logic        clk = 0, reset = 0;
    logic        req_valid = 0, req_ready, req_load = 0, req_store = 0, req_sext = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [1:0]  req_size = 0;
    logic        resp_valid, resp_ready = 0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_valid, mem_good = 0, mem_memRead, mem_memWrite, mem_sext;
    logic [31:0] mem_addr, mem_writeData, mem_readData = 0;
    logic [1:0]  mem_maskMode;
    int          checks = 0, errors = 0;
    logic [33:0] exp_q[$];
    logic        seen = 0;

    dmem_master #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_valid(mem_valid), .mem_good(mem_good),
        .mem_addr(mem_addr), .mem_writeData(mem_writeData), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_maskMode(mem_maskMode), .mem_sext(mem_sext),
        .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each new response against the oldest expectation
    always @(negedge clk) begin
        if (resp_valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %b expected none", resp_rdata, resp_err);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e[33:2]);
                chk("resp_err", {30'd0, resp_err}, {30'd0, e[1:0]});
            end
        end else if (!resp_valid) seen = 0;
    end

    task automatic send(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sx);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_load = ld; req_store = st; req_addr = a; req_wdata = wd; req_size = sz; req_sext = sx;
        req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic done_resp();
        @(negedge clk);
        chk("resp_drop", {31'd0, resp_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        int n;
        logic ok;
        #3;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // word load, minimum latency
        mem_good = 1; mem_readData = 32'hDEADBEEF; resp_ready = 1;
        exp_q.push_back({32'hDEADBEEF, 2'b00});
        send(1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("ld_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("ld_memRead", {31'd0, mem_memRead}, 32'd1);
        chk("ld_memWrite", {31'd0, mem_memWrite}, 32'd0);
        chk("ld_addr", mem_addr, 32'h10);
        chk("ld_mask", {30'd0, mem_maskMode}, 32'd2);
        chk("ld_no_early_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("ld_lat_n2", {31'd0, resp_valid}, 32'd1);
        chk("ld_mem_drop", {31'd0, mem_valid}, 32'd0);
        done_resp();

        // half store, readData must not leak into response
        mem_readData = 32'h12345678;
        exp_q.push_back({32'h0, 2'b00});
        send(0, 1, 32'h6, 32'h0000ABCD, 2'b01, 0);
        chk("st_memWrite", {31'd0, mem_memWrite}, 32'd1);
        chk("st_memRead", {31'd0, mem_memRead}, 32'd0);
        chk("st_mask", {30'd0, mem_maskMode}, 32'd1);
        chk("st_addr", mem_addr, 32'h6);
        chk("st_wdata", mem_writeData, 32'h0000ABCD);
        @(negedge clk);
        chk("st_resp", {31'd0, resp_valid}, 32'd1);
        chk("st_one_access", {31'd0, mem_valid}, 32'd0);
        chk("st_addr_hold", mem_addr, 32'h6);
        done_resp();

        // illegal requests: no memory access, error in cycle N+1
        exp_q.push_back({32'h0, 2'b01});
        send(1, 0, 32'h12, 32'h0, 2'b10, 0);
        chk("misal_resp", {31'd0, resp_valid}, 32'd1);
        chk("misal_no_mem", {31'd0, mem_valid}, 32'd0);
        done_resp();
        exp_q.push_back({32'h0, 2'b01});
        send(1, 1, 32'h0, 32'h0, 2'b10, 0);
        chk("both_resp", {31'd0, resp_valid}, 32'd1);
        chk("both_no_mem", {31'd0, mem_valid}, 32'd0);
        done_resp();
        exp_q.push_back({32'h0, 2'b01});
        send(1, 0, 32'h3, 32'h0, 2'b01, 0);
        chk("half_odd_no_mem", {31'd0, mem_valid}, 32'd0);
        done_resp();
        exp_q.push_back({32'h0, 2'b01});
        send(0, 0, 32'h0, 32'h0, 2'b00, 0);
        chk("neither_no_mem", {31'd0, mem_valid}, 32'd0);
        done_resp();
        exp_q.push_back({32'h0, 2'b01});
        send(1, 0, 32'h8, 32'h0, 2'b11, 0);
        chk("size11_no_mem", {31'd0, mem_valid}, 32'd0);
        done_resp();

        // byte load at odd address with sign-extension flag
        mem_readData = 32'hFFFFFF80;
        exp_q.push_back({32'hFFFFFF80, 2'b00});
        send(1, 0, 32'h3, 32'h0, 2'b00, 1);
        chk("byte_valid", {31'd0, mem_valid}, 32'd1);
        chk("byte_sext", {31'd0, mem_sext}, 32'd1);
        chk("byte_mask", {30'd0, mem_maskMode}, 32'd0);
        @(negedge clk);
        done_resp();

        // response backpressure; a pending request must not be taken
        mem_readData = 32'hCAFEF00D; resp_ready = 0;
        exp_q.push_back({32'hCAFEF00D, 2'b00});
        send(1, 0, 32'h20, 32'h0, 2'b10, 0);
        @(negedge clk);
        hold = resp_rdata;
        req_valid = 1; req_addr = 32'h24;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            if (!resp_valid || resp_rdata !== 32'hCAFEF00D || resp_err !== 2'b00 || req_ready) ok = 0;
            @(negedge clk);
        end
        chk("stall_stable", {31'd0, ok}, 32'd1);
        chk("stall_data", hold, 32'hCAFEF00D);
        resp_ready = 1;
        @(negedge clk);
        chk("hs_no_accept", {31'd0, mem_valid}, 32'd0);
        chk("hs_resp_drop", {31'd0, resp_valid}, 32'd0);
        req_valid = 0;
        mem_good = 0;
        @(negedge clk);

`ifdef DMEM_MASTER_TIMEOUT_EN
        exp_q.push_back({32'h0, 2'b10});
        send(1, 0, 32'h40, 32'h0, 2'b10, 0);
        n = 0;
        while (mem_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("to_access_cycles", n, 32'd4);
        chk("to_resp", {31'd0, resp_valid}, 32'd1);
        done_resp();
`else
        send(1, 0, 32'h40, 32'h0, 2'b10, 0);
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            if (!mem_valid || resp_valid) ok = 0;
            @(negedge clk);
        end
        chk("wait_forever", {31'd0, ok}, 32'd1);
        mem_readData = 32'h11112222;
        exp_q.push_back({32'h11112222, 2'b00});
        mem_good = 1;
        @(negedge clk);
        mem_good = 0;
        chk("late_good_resp", {31'd0, resp_valid}, 32'd1);
        done_resp();
`endif

        // reset mid-access
        send(1, 0, 32'h50, 32'h0, 2'b10, 0);
        chk("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
        #2 reset = 0;
        #1;
        chk("async_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("async_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);

        // first edge after reset release accepts
        reset = 1;
        mem_good = 1; mem_readData = 32'h0BADCAFE;
        exp_q.push_back({32'h0BADCAFE, 2'b00});
        send(1, 0, 32'h60, 32'h0, 2'b10, 0);
        chk("post_rst_accept", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        done_resp();
        mem_good = 0;
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
